// File: rtl/stream_argmax.sv
// stream_argmax: per-vector argmax over a valid/ready stream; defining STREAM_ARGMAX_RELU_EN clamps negative words to 0
module stream_argmax #(
   parameter int M = 8,
   parameter int T = 12,
   localparam int IW = $clog2(M)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          s_valid,
   input  logic [T-1:0]  data_in,
   output logic          s_ready,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [IW-1:0] idx_out,
   output logic [T-1:0]  max_out
);
   logic [IW-1:0] cnt, ridx, nidx;
   logic signed [T-1:0] rmax, d, nmax;
   logic last, acc, take;
   always_comb begin
`ifdef STREAM_ARGMAX_RELU_EN
      d = data_in[T-1] ? '0 : $signed(data_in);
`else
      d = $signed(data_in);
`endif
      last = cnt == IW'(M - 1);
      s_ready = !(last && m_valid && !m_ready);
      acc = s_valid && s_ready;
      // element 0 always seeds the running max; later ones need a strict win
      take = cnt == '0 || d > rmax;
      nmax = take ? d : rmax;
      nidx = take ? cnt : ridx;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         rmax <= '0;
         ridx <= '0;
         m_valid <= 1'b0;
         idx_out <= '0;
         max_out <= '0;
      end else begin
         if (acc) begin
            cnt <= last ? '0 : cnt + IW'(1);
            rmax <= nmax;
            ridx <= nidx;
         end
         if (acc && last) begin
            idx_out <= nidx;
            max_out <= nmax;
            m_valid <= 1'b1;
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end
endmodule
